instruction_prefetch: RTL and testbench
=======================================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 Parameter: DEPTH, 4, queue entries and max outstanding fetches; power of two, >= 2.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter: INVALID_INST, 32'hc0defec4, value driven on inst when valid is low.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: mem_fetch_addr  out  32  fetch request address.
REQ-007 Port: mem_fetch_addr_en  out  1  request issued this cycle.
REQ-008 Port: mem_inst_in  in  32  returned instruction word.
REQ-009 Port: mem_inst_valid  in  1  response strobe; in order, at most one per cycle, >= 1 cycle after its request.
REQ-010 Port: override_pc  in  1  redirect/flush request.
REQ-011 Port: override_pc_addr  in  32  redirect target.
REQ-012 Port: inst  out  32  head instruction.
REQ-013 Port: pc  out  32  address of head instruction (new vs. previous fetch stage).
REQ-014 Port: valid  out  1  head presented and consumed this cycle.
REQ-015 Port: stall  in  1  downstream cannot accept.

Function
REQ-016 Counters: occ (queue occupancy) and outst (issued, unanswered), each $clog2(DEPTH+1) bits; invariant occ + outst <= DEPTH at all times.
REQ-017 mem_fetch_addr_en = reset_n & ~override_pc & (occ + outst < DEPTH); mem_fetch_addr = fetch_addr register.
REQ-018 On each issued request fetch_addr <= fetch_addr + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-019 Response tracking: resp_pc register holds address of next expected response; increments by 4 per accepted response.
REQ-020 Accepted response (mem_inst_valid, drop_cnt == 0, ~override_pc) pushes {resp_pc, mem_inst_in} into queue; outst decrements.
REQ-021 Pushed entry visible at head no earlier than the cycle after the response (response-to-valid latency 1).
REQ-022 valid = (occ != 0) & ~stall & ~override_pc & reset_n; pop happens exactly when valid is high.
REQ-023 inst/pc = head entry when valid, else INVALID_INST / 32'h0.
REQ-024 Push and pop in same cycle: occ unchanged, both take effect; push into full queue cannot occur (credit rule REQ-016).
REQ-025 override_pc: queue emptied, fetch_addr and resp_pc <= override_pc_addr, drop_cnt <= outst minus (1 if response arrives that cycle), outst <= 0 for credit purposes only after drops retire (credits = occ + outst + drop_cnt).
REQ-026 Response in override cycle is discarded and never presented.
REQ-027 States: RUN (drop_cnt == 0) and DRAIN (drop_cnt > 0); RUN->DRAIN on override with nonzero remaining outstanding; DRAIN decrements drop_cnt per response, discards it, ->RUN when it reaches 0; new requests permitted in DRAIN within credits.
REQ-028 override_pc during DRAIN: drop_cnt recomputed per REQ-025 including existing drops; redirect target replaces prior one.
REQ-029 stall has no effect on issuing requests; only credits throttle fetch.

Reset
REQ-030 reset_n low asynchronously: fetch_addr = resp_pc = RESET_PC, occ = outst = drop_cnt = 0, state RUN, queue empty.
REQ-031 During reset: mem_fetch_addr_en = 0, valid = 0, inst = INVALID_INST, pc = 0; responses ignored; reset mid-flight drops all outstanding without tracking.
REQ-032 First request issued on first clock edge after reset_n deasserts, address RESET_PC.

Structure
REQ-033 Shared package fetch_pkg: INVALID_INST default, state enum {RUN, DRAIN}, entry struct {pc, inst}.
REQ-034 Storage in sub-module fetch_queue (synchronous FIFO, DEPTH entries, push/pop/flush, occupancy out); control logic in instruction_prefetch.

Verification
REQ-035 Reset release, memory latency 1, stall 0 -> requests 0x0,0x4,0x8,0x0C on consecutive cycles; valid from cycle 3 with pc 0x0,0x4,... one per cycle.
REQ-036 stall held 10 cycles, DEPTH=4 -> exactly 4 requests issued, en low after, occ=4; stall release -> 4 back-to-back valids, pc 0x0..0xC, fetching resumes.
REQ-037 3 requests outstanding, override_pc to 0x100 -> next 3 responses discarded, first valid pc = 0x100 with 0x100 response data.
REQ-038 Override in same cycle as response and as second override during DRAIN (target 0x200) -> no stale instruction presented, first valid pc = 0x200.
REQ-039 RESET_PC=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc outputs match.
REQ-040 Assert reset_n low with 2 outstanding, release -> outputs at reset values immediately, late stale responses ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetcher: queue entry layout, the
// drain-tracking state, and the value presented when no instruction is valid.
package fetch_pkg;

    localparam logic [31:0] INVALID_INST_DEFAULT = 32'hc0defec4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with flush and occupancy.
// A push becomes visible at the head on the cycle after it is written.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output entry_t        head_o,
    output logic [CW-1:0] occ_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          push_ok, pop_ok;

    // Guards keep the pointers coherent even if a caller breaks the credit rule.
    assign push_ok = push_i & ~flush_i & (occ_q != CW'(DEPTH));
    assign pop_ok  = pop_i  & ~flush_i & (occ_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   occ_d = occ_q + CW'(1);
                2'b01:   occ_d = occ_q - CW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/instruction_prefetch.sv
// Credit-limited instruction prefetcher: issues sequential fetches, queues
// in-order responses, and discards responses still in flight after a redirect.
//   state | meaning
//   RUN   | no stale responses pending; responses are queued
//   DRAIN | drop_cnt stale responses still due; each one is discarded
module instruction_prefetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] INVALID_INST = INVALID_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_fetch_addr,
    output logic        mem_fetch_addr_en,
    input  logic [31:0] mem_inst_in,
    input  logic        mem_inst_valid,
    input  logic        override_pc,
    input  logic [31:0] override_pc_addr,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid,
    input  logic        stall
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    state_e        state_q, state_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] occ;
    logic [SW-1:0] credits_used;
    logic [SW-1:0] inflight;
    logic          issue, accept, discard;
    entry_t        head, push_entry;

    // Stale responses still hold a credit until they come back.
    assign inflight     = SW'(outst_q) + SW'(drop_q);
    assign credits_used = SW'(occ) + inflight;

    assign issue   = reset_n & ~override_pc & (credits_used < SW'(DEPTH));
    // A response with nothing tracked (e.g. left over from before reset) is ignored.
    assign accept  = mem_inst_valid & ~override_pc & (state_q == RUN) & (outst_q != '0);
    assign discard = mem_inst_valid & ~override_pc & (state_q == DRAIN);

    assign push_entry = '{pc: resp_pc_q, inst: mem_inst_in};

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        resp_pc_d    = resp_pc_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        if (override_pc) begin
            fetch_addr_d = override_pc_addr;
            resp_pc_d    = override_pc_addr;
            outst_d      = '0;
            // Everything still in flight becomes stale; a response arriving
            // this very cycle retires the oldest of them.
            if (mem_inst_valid && (inflight != '0)) begin
                drop_d = CW'(inflight - SW'(1));
            end else begin
                drop_d = CW'(inflight);
            end
        end else begin
            if (issue)   fetch_addr_d = fetch_addr_q + 32'd4;
            if (accept)  resp_pc_d    = resp_pc_q + 32'd4;
            if (discard) drop_d       = drop_q - CW'(1);
            case ({issue, accept})
                2'b10:   outst_d = outst_q + CW'(1);
                2'b01:   outst_d = outst_q - CW'(1);
                default: outst_d = outst_q;
            endcase
        end
        state_d = (drop_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            fetch_addr_q <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            outst_q      <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            resp_pc_q    <= resp_pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH),
        .CW   (CW)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (accept),
        .push_data_i(push_entry),
        .pop_i      (valid),
        .flush_i    (override_pc),
        .head_o     (head),
        .occ_o      (occ)
    );

    assign mem_fetch_addr    = fetch_addr_q;
    assign mem_fetch_addr_en = issue;

    assign valid = (occ != '0) & ~stall & ~override_pc & reset_n;
    assign inst  = valid ? head.inst : INVALID_INST;
    assign pc    = valid ? head.pc   : 32'h0;

endmodule

// File: tb/tb_instruction_prefetch.sv
// Self-checking bench for instruction_prefetch: a memory model with random
// latency plus a program-order model of what the consumer must observe.
module tb_instruction_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] INV   = 32'hc0defec4;

    logic        clk;
    logic        reset_n;
    logic [31:0] mem_fetch_addr;
    logic        mem_fetch_addr_en;
    logic [31:0] mem_inst_in;
    logic        mem_inst_valid;
    logic        override_pc;
    logic [31:0] override_pc_addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        stall;

    logic        w_rst_n;
    logic [31:0] w_addr;
    logic        w_en;
    logic [31:0] w_mem_in;
    logic        w_mem_valid;
    logic        w_ovr;
    logic [31:0] w_ovr_addr;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_valid;
    logic        w_stall;

    instruction_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0), .INVALID_INST(INV)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_fetch_addr(mem_fetch_addr), .mem_fetch_addr_en(mem_fetch_addr_en),
        .mem_inst_in(mem_inst_in), .mem_inst_valid(mem_inst_valid),
        .override_pc(override_pc), .override_pc_addr(override_pc_addr),
        .inst(inst), .pc(pc), .valid(valid), .stall(stall)
    );

    instruction_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .INVALID_INST(INV)) dut_wrap (
        .clk(clk), .reset_n(w_rst_n),
        .mem_fetch_addr(w_addr), .mem_fetch_addr_en(w_en),
        .mem_inst_in(w_mem_in), .mem_inst_valid(w_mem_valid),
        .override_pc(w_ovr), .override_pc_addr(w_ovr_addr),
        .inst(w_inst), .pc(w_pc), .valid(w_valid), .stall(w_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        bit          live;
        int          due;
    } req_t;

    req_t        pend[$];    // requests the memory has not answered yet
    logic [31:0] mq[$];      // pcs accepted but not yet consumed
    logic [31:0] next_fetch;
    int          cyc;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          inject_stale = 0;
    bit          rsp;
    bit          exp_en, exp_valid;
    logic [31:0] exp_pc, exp_inst;
    logic [97:0] exp_vec, obs_vec;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    // Drive one cycle's inputs (called at a negedge) and compute expectations.
    task automatic cycle(input bit s, input bit o, input logic [31:0] oa);
        stall            = s;
        override_pc      = o;
        override_pc_addr = oa;
        rsp = 1'b0;
        if (pend.size() != 0) begin
            if (pend[0].due <= cyc) rsp = 1'b1;
        end
        mem_inst_valid = rsp | inject_stale;
        mem_inst_in    = rsp ? mem_word(pend[0].addr) : 32'hdead_beef;
        #1;
        exp_en    = !o && ((pend.size() + mq.size()) < DEPTH);
        exp_valid = (mq.size() != 0) && !s && !o;
        exp_pc    = exp_valid ? mq[0] : 32'h0;
        exp_inst  = exp_valid ? mem_word(mq[0]) : INV;
        exp_vec   = {exp_en, exp_en ? next_fetch : 32'h0, exp_valid, exp_pc, exp_inst};
        obs_vec   = {mem_fetch_addr_en, mem_fetch_addr_en ? mem_fetch_addr : 32'h0, valid, pc, inst};
    endtask

    // Advance the model by the clock edge that ends the current cycle.
    task automatic commit();
        req_t r;
        if (exp_valid) void'(mq.pop_front());
        if (rsp) begin
            r = pend.pop_front();
            if (r.live && !override_pc) mq.push_back(r.addr);
        end
        if (override_pc) begin
            mq.delete();
            foreach (pend[i]) pend[i].live = 1'b0;
            next_fetch = override_pc_addr;
        end
        if (exp_en) begin
            r.addr = next_fetch;
            r.live = 1'b1;
            r.due  = cyc + int'($urandom_range(lat_max, lat_min));
            pend.push_back(r);
            next_fetch = next_fetch + 32'd4;
        end
        cyc++;
        @(negedge clk);
        mem_inst_valid = 1'b0;
    endtask

    task automatic clear_model();
        pend.delete();
        mq.delete();
        next_fetch   = 32'h0;
        cyc          = 0;
        inject_stale = 1'b0;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        stall          = 1'b0;
        override_pc    = 1'b0;
        mem_inst_valid = 1'b0;
        @(negedge clk);
        clear_model();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; override_pc = 1'b0; override_pc_addr = 32'h0;
        mem_inst_valid = 1'b1; mem_inst_in = 32'h1111_2222;
        w_rst_n = 1'b0; w_stall = 1'b0; w_ovr = 1'b0; w_ovr_addr = 32'h0;
        w_mem_valid = 1'b0; w_mem_in = 32'h0;
        @(negedge clk);
        @(negedge clk);
        if (mem_fetch_addr_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", mem_fetch_addr_en); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (inst !== INV) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, INV); end
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
        checks++;
        if (mem_fetch_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_fetch_addr); end
        checks++;
        mem_inst_valid = 1'b0;
        clear_model();
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        int first_valid = -1;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            if (valid && first_valid < 0) first_valid = i;
            commit();
        end
        if (first_valid !== 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", first_valid); end
        checks++;
    endtask

    task automatic test_stall_fill();
        int  n_req = 0;
        int  n_val = 0;
        bit  last_en = 1'b1;
        bit  any_en = 1'b0;
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL stall cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            n_req  += int'(mem_fetch_addr_en);
            last_en = mem_fetch_addr_en;
            commit();
        end
        if (n_req !== 4) begin failures++; $display("FAIL stall_requests got=%0d exp=4", n_req); end
        checks++;
        if (last_en !== 1'b0) begin failures++; $display("FAIL stall_en_low got=%b exp=0", last_en); end
        checks++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL unstall cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            if (valid && pc !== 32'(i * 4)) begin failures++; $display("FAIL unstall_pc got=%h exp=%h", pc, 32'(i * 4)); end
            checks++;
            n_val  += int'(valid);
            any_en |= mem_fetch_addr_en;
            commit();
        end
        if (n_val !== 4) begin failures++; $display("FAIL unstall_valids got=%0d exp=4", n_val); end
        checks++;
        if (any_en !== 1'b1) begin failures++; $display("FAIL unstall_resume got=%b exp=1", any_en); end
        checks++;
    endtask

    task automatic test_override();
        logic [31:0] first_pc = 32'hffff_ffff;
        logic [31:0] first_inst = 32'h0;
        bit          seen = 1'b0;
        do_reset();
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL ovr_pre cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            commit();
        end
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, i == 0, 32'h100);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL ovr cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            if (valid && !seen) begin seen = 1'b1; first_pc = pc; first_inst = inst; end
            commit();
        end
        if (first_pc !== 32'h100) begin failures++; $display("FAIL ovr_first_pc got=%h exp=00000100", first_pc); end
        checks++;
        if (first_inst !== mem_word(32'h100)) begin failures++; $display("FAIL ovr_first_inst got=%h exp=%h", first_inst, mem_word(32'h100)); end
        checks++;
    endtask

    task automatic test_override_drain();
        logic [31:0] first_pc = 32'hffff_ffff;
        bit          seen = 1'b0;
        bit          hit_rsp = 1'b0;
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            if (pend.size() >= 2 && pend[0].due <= cyc) break;
            cycle(1'b0, 1'b0, 32'h0);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL drain_pre cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            commit();
        end
        cycle(1'b0, 1'b1, 32'h180);
        hit_rsp = rsp;
        if (obs_vec !== exp_vec) begin failures++; $display("FAIL drain_ovr1 got=%h exp=%h", obs_vec, exp_vec); end
        checks++;
        commit();
        cycle(1'b0, 1'b1, 32'h200);
        if (obs_vec !== exp_vec) begin failures++; $display("FAIL drain_ovr2 got=%h exp=%h", obs_vec, exp_vec); end
        checks++;
        commit();
        if (hit_rsp !== 1'b1) begin failures++; $display("FAIL drain_setup got=%b exp=1", hit_rsp); end
        checks++;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL drain cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            if (valid && !seen) begin seen = 1'b1; first_pc = pc; end
            commit();
        end
        if (first_pc !== 32'h200) begin failures++; $display("FAIL drain_first_pc got=%h exp=00000200", first_pc); end
        checks++;
    endtask

    task automatic test_wrap();
        logic [31:0] wexp [3];
        logic [31:0] reqs[$];
        logic [31:0] pcs[$];
        logic [31:0] prev_addr = 32'h0;
        logic [31:0] got;
        bit          prev_en = 1'b0;
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
        w_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_mem_valid = prev_en;
            w_mem_in    = mem_word(prev_addr);
            #1;
            if (w_en) reqs.push_back(w_addr);
            if (w_valid) begin
                pcs.push_back(w_pc);
                if (w_inst !== mem_word(w_pc)) begin failures++; $display("FAIL wrap_inst got=%h exp=%h", w_inst, mem_word(w_pc)); end
                checks++;
            end
            prev_en   = w_en;
            prev_addr = w_addr;
            @(negedge clk);
        end
        w_mem_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got = (k < reqs.size()) ? reqs[k] : 32'hxxxx_xxxx;
            if (got !== wexp[k]) begin failures++; $display("FAIL wrap_req%0d got=%h exp=%h", k, got, wexp[k]); end
            checks++;
            got = (k < pcs.size()) ? pcs[k] : 32'hxxxx_xxxx;
            if (got !== wexp[k]) begin failures++; $display("FAIL wrap_pc%0d got=%h exp=%h", k, got, wexp[k]); end
            checks++;
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] first_pc = 32'hffff_ffff;
        bit          seen = 1'b0;
        do_reset();
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL mid_pre cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            commit();
        end
        stall = 1'b0;
        reset_n = 1'b0;
        #1;
        if ({mem_fetch_addr_en, valid, pc, inst} !== {1'b0, 1'b0, 32'h0, INV}) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=%h", {mem_fetch_addr_en, valid, pc, inst}, {1'b0, 1'b0, 32'h0, INV});
        end
        checks++;
        mem_inst_valid = 1'b1;
        mem_inst_in    = 32'hbad0_0001;
        @(negedge clk);
        mem_inst_valid = 1'b0;
        clear_model();
        reset_n = 1'b1;
        lat_min = 1; lat_max = 1;
        inject_stale = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        if (obs_vec !== exp_vec) begin failures++; $display("FAIL mid_restart got=%h exp=%h", obs_vec, exp_vec); end
        checks++;
        commit();
        inject_stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL mid cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            if (valid && !seen) begin seen = 1'b1; first_pc = pc; end
            commit();
        end
        if (first_pc !== 32'h0) begin failures++; $display("FAIL mid_first_pc got=%h exp=00000000", first_pc); end
        checks++;
    endtask

    task automatic test_random();
        int          n_valid = 0;
        bit          s, o;
        logic [31:0] oa;
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            s  = ($urandom_range(9, 0) < 3);
            o  = ($urandom_range(39, 0) == 0);
            oa = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                             : ($urandom() & 32'hFFFF_FFFC);
            cycle(s, o, oa);
            if (obs_vec !== exp_vec) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec); end
            checks++;
            n_valid += int'(valid);
            commit();
        end
        if (n_valid < 100) begin failures++; $display("FAIL random_activity got=%0d exp>=100", n_valid); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_override();
        test_override_drain();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
